// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, size codes and byte-enable helper for mem_arbiter
package mem_pkg;

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D, RESP} state_t;

   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;
   localparam logic [2:0] SZ_D = 3'd3;

   localparam int TMO_W = 16;

   function automatic logic [7:0] size_strb(input logic [2:0] size, input logic [2:0] off);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - shifts a full bus word down to the addressed field and extends it
module mem_load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      off,
   input  logic [2:0]      size,
   input  logic            sgn,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic            msb;

   always_comb begin
      sh   = rdata >> {off, 3'b000};
      mask = '1;
      msb  = 1'b0;
      case (size)
         SZ_B: begin mask = XLEN'(8'hFF);         msb = sh[7];  end
         SZ_H: begin mask = XLEN'(16'hFFFF);      msb = sh[15]; end
         SZ_W: begin mask = XLEN'(32'hFFFF_FFFF); msb = sh[31]; end
         default: begin mask = '1; msb = 1'b0; end
      endcase
      data = (sh & mask) | ((sgn & msb) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one memory bus with lane alignment
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int              XLEN    = 64,
   parameter logic [TMO_W-1:0] TIMEOUT = 16'd1023
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic [XLEN-1:0]   if_rdata,
   output logic              if_ready,
   output logic              if_error,
   input  logic              d_read_req,
   input  logic              d_write_req,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [2:0]        d_size,
   input  logic              d_signed,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_ready,
   output logic              d_error,
   output logic              d_misaligned,
   output logic              bus_valid,
   output logic              bus_write,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_strb,
   input  logic [XLEN-1:0]   bus_rdata,
   input  logic              bus_ready,
   input  logic              bus_error
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   state_t           state;
   logic             last_d;
   logic             grant_d;
   logic [OW-1:0]    off_r;
   logic [2:0]       size_r;
   logic             sgn_r;
   logic [TMO_W-1:0] wait_cnt;
   logic [XLEN-1:0]  ld_data;
   logic             pick_d;
   logic             mis;
   logic [OW-1:0]    d_off;
   logic [7:0]       strb_full;

   // Data wins unless fetch is also pending and data was granted last.
   always_comb begin
      pick_d    = (d_read_req | d_write_req) & (~if_req | ~last_d);
      d_off     = d_addr[OW-1:0];
      strb_full = size_strb(d_size, 3'(d_off));
      case (d_size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = d_addr[0];
         SZ_W:    mis = |d_addr[1:0];
         SZ_D:    mis = (XLEN == 32) || (|d_addr[2:0]);
         default: mis = 1'b1;
      endcase
   end

   mem_load_align #(.XLEN(XLEN)) u_align (
      .rdata (bus_rdata),
      .off   (3'(off_r)),
      .size  (size_r),
      .sgn   (sgn_r),
      .data  (ld_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         last_d       <= 1'b0;
         grant_d      <= 1'b0;
         off_r        <= '0;
         size_r       <= SZ_B;
         sgn_r        <= 1'b0;
         wait_cnt     <= '0;
         if_rdata     <= '0;
         if_ready     <= 1'b0;
         if_error     <= 1'b0;
         d_rdata      <= '0;
         d_ready      <= 1'b0;
         d_error      <= 1'b0;
         d_misaligned <= 1'b0;
         bus_valid    <= 1'b0;
         bus_write    <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_strb     <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (pick_d) begin
                  grant_d <= 1'b1;
                  if (mis) begin
                     d_error      <= 1'b1;
                     d_misaligned <= 1'b1;
                     state        <= RESP;
                  end else begin
                     bus_valid <= 1'b1;
                     bus_write <= d_write_req;
                     bus_addr  <= {d_addr[XLEN-1:OW], {OW{1'b0}}};
                     bus_strb  <= d_write_req ? strb_full[NB-1:0] : '1;
                     bus_wdata <= d_write_req ? d_wdata << {d_off, 3'b000} : '0;
                     off_r     <= d_off;
                     size_r    <= d_size;
                     sgn_r     <= d_signed;
                     state     <= BUS_D;
                  end
               end else if (if_req) begin
                  grant_d   <= 1'b0;
                  bus_valid <= 1'b1;
                  bus_write <= 1'b0;
                  bus_addr  <= {if_addr[XLEN-1:OW], {OW{1'b0}}};
                  bus_strb  <= '1;
                  bus_wdata <= '0;
                  off_r     <= if_addr[OW-1:0];
                  size_r    <= SZ_W;
                  sgn_r     <= 1'b0;
                  state     <= BUS_IF;
               end
            end
            BUS_IF, BUS_D: begin
               if (bus_ready || bus_error) begin
                  bus_valid <= 1'b0;
                  state     <= RESP;
                  if (grant_d) begin
                     d_error <= bus_error;
                     d_ready <= ~bus_error;
                     if (!bus_write) d_rdata <= ld_data;
                  end else begin
                     if_error <= bus_error;
                     if_ready <= ~bus_error;
                     if_rdata <= ld_data;
                  end
               end else if ((TIMEOUT != '0) && (wait_cnt == TIMEOUT - TMO_W'(1))) begin
                  bus_valid <= 1'b0;
                  state     <= RESP;
                  if (grant_d) d_error <= 1'b1;
                  else         if_error <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TMO_W'(1);
               end
            end
            RESP: begin
               if_ready     <= 1'b0;
               if_error     <= 1'b0;
               d_ready      <= 1'b0;
               d_error      <= 1'b0;
               d_misaligned <= 1'b0;
               last_d       <= grant_d;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req;
   logic [63:0] if_addr, if_rdata;
   logic        if_ready, if_error;
   logic        d_read_req, d_write_req;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [2:0]  d_size;
   logic        d_signed, d_ready, d_error, d_misaligned;
   logic        bus_valid, bus_write;
   logic [63:0] bus_addr, bus_wdata, bus_rdata;
   logic [7:0]  bus_strb;
   logic        bus_ready, bus_error;

   int checks   = 0;
   int failures = 0;
   bit model_last_d = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.XLEN(64), .TIMEOUT(16'd4)) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .if_error(if_error),
      .d_read_req(d_read_req), .d_write_req(d_write_req),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .d_signed(d_signed),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error), .d_misaligned(d_misaligned),
      .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_rdata(bus_rdata),
      .bus_ready(bus_ready), .bus_error(bus_error)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ld_model(input logic [63:0] rd, input int off, input int n, input bit sg);
      logic [63:0] v;
      v = rd >> (8 * off);
      if (n < 8) begin
         v = v % (64'd1 << (8 * n));
         if (sg && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      end
      return v;
   endfunction

   // dk: 0 none, 1 load, 2 store. rmode: 0 ready, 1 error, 2 both. waits >= TO means silent bus.
   task automatic run_txn(input bit use_if, input logic [63:0] ia, input int dk,
                          input logic [63:0] da, input logic [63:0] wd, input logic [2:0] sz,
                          input bit sg, input int waits, input int rmode, input logic [63:0] rd);
      bit          win_d, mis, err, is_st;
      int          off, n, pulse;
      logic [63:0] exp_addr, exp_wdata;
      logic [7:0]  exp_strb;
      logic [4:0]  exp_p;
      if (!use_if && dk == 0) return;
      win_d = (dk != 0) && (!use_if || !model_last_d);
      is_st = win_d && dk == 2;
      off   = win_d ? int'(da % 8) : int'(ia % 8);
      n     = win_d ? (1 << sz) : 4;
      mis   = win_d && (sz > 3 || (da % n) != 0);
      err   = mis || waits >= TO || rmode != 0;
      pulse = mis ? 1 : (waits >= TO ? TO + 1 : waits + 2);
      exp_addr  = (win_d ? da : ia) / 8 * 8;
      exp_strb  = 8'hFF;
      exp_wdata = 64'd0;
      if (is_st && !mis) begin
         exp_strb = 8'h00;
         for (int i = 0; i < n; i++) exp_strb[off + i] = 1'b1;
         exp_wdata = wd << (8 * off);
      end

      if_req = use_if; if_addr = ia;
      d_read_req = (dk == 1); d_write_req = (dk == 2);
      d_addr = da; d_wdata = wd; d_size = sz; d_signed = sg; bus_rdata = rd;

      for (int c = 1; c <= pulse; c++) begin
         @(negedge clk);
         bus_ready = 1'b0;
         bus_error = 1'b0;
         check_eq("bus_valid", bus_valid, (!mis && c < pulse));
         if (c == 1 && !mis) begin
            check_eq("bus_addr", bus_addr, exp_addr);
            check_eq("bus_write", bus_write, is_st);
            check_eq("bus_strb", bus_strb, exp_strb);
            if (is_st) check_eq("bus_wdata", bus_wdata, exp_wdata);
         end
         exp_p = 5'd0;
         if (c == pulse) exp_p = win_d ? {2'b00, !err, err, mis} : {!err, err, 3'b000};
         check_eq("pulses", {if_ready, if_error, d_ready, d_error, d_misaligned}, exp_p);
         if (c == pulse && !err && !is_st) begin
            if (win_d) check_eq("d_rdata", d_rdata, ld_model(rd, off, n, sg));
            else       check_eq("if_rdata", if_rdata, ld_model(rd, off, 4, 1'b0));
         end
         if (!mis && waits < TO && c == waits + 1) begin
            bus_ready = (rmode != 1);
            bus_error = (rmode != 0);
         end
      end
      if_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;
      model_last_d = win_d;
      @(negedge clk);
      check_eq("idle_gap", {bus_valid, if_ready, if_error, d_ready, d_error}, 64'd0);
   endtask

   bit          r_if;
   int          r_dk, r_waits, r_rmode;
   logic [2:0]  r_sz;
   logic [63:0] r_da, r_ia, r_wd;

   initial begin
      resetn = 1'b0; if_req = 1'b0; if_addr = '0;
      d_read_req = 1'b0; d_write_req = 1'b0; d_addr = '0; d_wdata = '0;
      d_size = 3'd0; d_signed = 1'b0; bus_rdata = '0; bus_ready = 1'b0; bus_error = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ctl", {bus_valid, bus_write, if_ready, if_error, d_ready, d_error, d_misaligned}, 64'd0);
      check_eq("rst_strb", bus_strb, 64'd0);
      check_eq("rst_if_rdata", if_rdata, 64'd0);
      check_eq("rst_d_rdata", d_rdata, 64'd0);
      check_eq("rst_bus_addr", bus_addr, 64'd0);
      resetn = 1'b1;

      // tie after reset: D, IF, D
      run_txn(1, 64'h2000, 1, 64'h3008, 0, 3'd3, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
      run_txn(1, 64'h2004, 1, 64'h3008, 0, 3'd3, 0, 1, 0, 64'h1111_2222_3333_4444);
      run_txn(1, 64'h2008, 1, 64'h3010, 0, 3'd2, 0, 0, 0, 64'h5555_6666_7777_8888);

      run_txn(1, 64'h1004, 0, 0, 0, 3'd0, 0, 0, 0, 64'hAABB_CCDD_1122_3344);
      check_eq("fetch_const", if_rdata, 64'h0000_0000_AABB_CCDD);

      run_txn(0, 0, 1, 64'h4003, 0, 3'd0, 1, 0, 0, 64'h0000_0000_8000_0000);
      check_eq("lb_signed_const", d_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      run_txn(0, 0, 1, 64'h4003, 0, 3'd0, 0, 0, 0, 64'h0000_0000_8000_0000);
      check_eq("lb_unsigned_const", d_rdata, 64'h80);

      run_txn(0, 0, 2, 64'h5006, 64'h1234, 3'd1, 0, 0, 0, 64'd0);
      run_txn(0, 0, 1, 64'h6002, 0, 3'd2, 0, 0, 0, 64'd0);
      run_txn(0, 0, 1, 64'h7000, 0, 3'd3, 0, 99, 0, 64'd0);
      run_txn(0, 0, 1, 64'h7008, 0, 3'd3, 0, TO - 1, 0, 64'hDEAD_BEEF_0000_0001);
      run_txn(0, 0, 1, 64'h7010, 0, 3'd3, 0, 1, 2, 64'd0);
      run_txn(1, 64'h7100, 0, 0, 0, 3'd0, 0, 0, 1, 64'd0);

      // leave last grant at D, then reset while a data access is on the bus
      run_txn(0, 0, 1, 64'h100, 0, 3'd3, 0, 0, 0, 64'd7);
      d_read_req = 1'b1; d_addr = 64'h200; d_size = 3'd3; d_signed = 1'b0;
      @(negedge clk);
      check_eq("rst_pre_valid", bus_valid, 64'd1);
      #2 resetn = 1'b0;
      #1 check_eq("rst_async_valid", bus_valid, 64'd0);
      d_read_req = 1'b0;
      model_last_d = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_eq("rst_no_pulse", {bus_valid, if_ready, if_error, d_ready, d_error, d_misaligned}, 64'd0);
      end
      resetn = 1'b1;
      run_txn(1, 64'h300, 1, 64'h308, 0, 3'd3, 0, 0, 0, 64'h9999_AAAA_BBBB_CCCC);

      for (int t = 0; t < 150; t++) begin
         r_if = 1'($urandom_range(0, 1));
         r_dk = $urandom_range(0, 2);
         if (!r_if && r_dk == 0) r_dk = 1;
         r_sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         r_da = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) r_da[2:0] = 3'd0;
         r_ia = {$urandom, $urandom};
         r_ia[1:0] = 2'd0;
         r_wd = {$urandom, $urandom};
         r_waits = $urandom_range(0, 5);
         r_rmode = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
         run_txn(r_if, r_ia, r_dk, r_da, r_wd, r_sz, 1'($urandom_range(0, 1)),
                 r_waits, r_rmode, {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single unified memory bus between the instruction-fetch port and the data port that the memory-access stage drives. It arbitrates between the two requesters and drives one bus transaction at a time. For data accesses it performs byte-lane alignment: write strobes and shifted write data on stores, shifted and sign/zero-extended read data on loads. It returns a registered ready or error pulse to the winning requester. The block sits between the pipeline memory ports and the SoC memory/bus interconnect.

## Interface
Parameters:
- XLEN, 64, data/address width; 32 or 64 only.
- TIMEOUT, 16'd1023, maximum bus wait cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; level, held until if_ready or if_error.
- if_addr  in  XLEN  fetch address; must be 4-byte aligned.
- if_rdata  out  XLEN  fetch data; zero-extended 32-bit word.
- if_ready / if_error  out  1  one-cycle completion pulses.
- d_read_req / d_write_req  in  1  data load/store request; level, mutually exclusive.
- d_addr, d_wdata  in  XLEN  data address and store data (right-justified).
- d_size  in  3  0=byte, 1=half, 2=word, 3=double.
- d_signed  in  1  sign-extend loads.
- d_rdata  out  XLEN  aligned, extended load data.
- d_ready / d_error  out  1  one-cycle completion pulses.
- d_misaligned  out  1  qualifies d_error: the access was misaligned or had an illegal size.
- bus_valid  out  1  transaction active; fields stable while high.
- bus_write  out  1  store.
- bus_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_strb  out  XLEN/8  byte enables; all ones for reads.
- bus_rdata  in  XLEN  full-width read data.
- bus_ready / bus_error  in  1  completion, sampled only while bus_valid.

## Operation
- States: IDLE, BUS_IF, BUS_D, RESP.
- IDLE:
  - A misaligned data request (addr not a multiple of 1<<d_size) goes to RESP with d_error=1 and d_misaligned=1, and no bus cycle.
  - An illegal data size (d_size=3 with XLEN=32) behaves the same way.
  - Otherwise a pending request goes to BUS_IF or BUS_D.
- Tie break: the grant goes to the requester not granted last. last_grant resets to IF, so data wins the first tie.
- BUS_x:
  - bus_valid=1 until bus_ready or bus_error is seen, then go to RESP.
  - bus_error beats bus_ready in the same cycle.
  - Each cycle without a response increments the wait counter. At TIMEOUT the state goes to RESP with error=1.
  - A response in the same cycle as timeout expiry wins over the timeout.
- RESP: pulse exactly one of ready/error to the granted requester, update last_grant, return to IDLE. The requester drops or changes its request in the following cycle, so there are no double grants.
- Lane offset: off = addr mod XLEN/8.
- Store lanes:
  - bus_strb = ((1<<(1<<size))-1) << off.
  - bus_wdata = d_wdata << 8*off.
- Load result: field = bus_rdata >> 8*off, truncated to 8<<size bits, then sign- or zero-extended to XLEN per d_signed.
- Fetch data: if_rdata = 32-bit word at offset if_addr mod XLEN/8, zero-extended.
- Read data and error are registered at the end of BUS_x and held until the next RESP.
- Reset values of all outputs: 0, including bus_strb, if_rdata, d_rdata and d_misaligned.

## Timing
- Outputs registered.
- Request seen in IDLE at cycle N gives bus_valid at N+1.
- bus_ready at cycle M gives the ready pulse at M+1.
- Minimum latency, zero-wait bus: request N, pulse N+2.
- Misaligned access: request N, d_error at N+1.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, BUS, RESP).
- Reset asserted mid-transaction drops bus_valid immediately (asynchronous). No pulse is issued and last_grant returns to IF.
- Requests arriving during BUS_x or RESP wait; the request level is not latched.

## Structure
- Package mem_pkg holds:
  - the state enum typedef;
  - size localparams (SZ_B/H/W/D);
  - function size_strb(size, off) returning the byte-enable mask;
  - TIMEOUT counter width localparam.
- Sub-module mem_load_align (combinational): inputs bus_rdata, offset, size, signed; output extended data. It is reused by the fetch path with size=word, signed=0.

## Test plan
- Reset, then lone fetch at if_addr=0x1004 with zero-wait bus_rdata=0xAABBCCDD_11223344 -> bus_valid cycle 1, if_rdata=0xAABBCCDD, if_ready cycle 2.
- Simultaneous if_req and d_read_req after reset -> data granted first, fetch next. With both requests held, grants alternate D, IF, D.
- Signed byte load at 0x...03, bus_rdata byte3=0x80 -> d_rdata=0xFFFF_FFFF_FFFF_FF80. The same with d_signed=0 -> 0x80.
- Half store at 0x...06, d_wdata=0x1234 -> bus_strb=0xC0, bus_wdata[63:48]=0x1234, bus_write=1.
- Word load at 0x...02 -> d_error=1, d_misaligned=1 one cycle later, bus_valid never asserted.
- TIMEOUT=4, bus never responds -> d_error after 4 wait cycles, bus_valid drops. Separately, bus_ready and bus_error together -> error reported. resetn low mid-BUS_D -> bus_valid=0 immediately, no pulse.
